// File: rtl/gpio_io.sv
// gpio_io: CSR GPIO peripheral, seven-segment display latch and debounced switch reader.
// Define GPIO_HEX_BLANK_LZ_EN to blank leading zero digits HEX7..HEX1.
module gpio_io #(
  parameter int NUM_SW = 18,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gpio_we,
  input  logic [31:0]       gpio_wdata,
  input  logic [NUM_SW-1:0] SW,
  output logic [31:0]       gpio_rdata,
  output logic              sw_changed,
  output logic [31:0]       hex_value,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic [6:0]        HEX6,
  output logic [6:0]        HEX7
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [NUM_SW-1:0] s1, s2, h0, h1, stable, upd;
  logic [CW-1:0] cnt;
  logic tick;
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'b1000000;
      4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;
      4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;
      4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;
      4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0010000;
      4'ha: font = 7'b0001000;
      4'hb: font = 7'b0000011;
      4'hc: font = 7'b1000110;
      4'hd: font = 7'b0100001;
      4'he: font = 7'b0000110;
      default: font = 7'b0001110;
    endcase
  endfunction
  // the incoming sample plus the two held ones form the three newest samples
  always_comb begin
    tick = cnt == CW'(DEBOUNCE_CYCLES - 1);
    upd = {NUM_SW{tick}} & ~(s2 ^ h0) & ~(s2 ^ h1) & (s2 ^ stable);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      h0 <= '0;
      h1 <= '0;
      cnt <= '0;
      stable <= '0;
      sw_changed <= 1'b0;
      hex_value <= '0;
    end else begin
      s1 <= SW;
      s2 <= s1;
      cnt <= tick ? '0 : cnt + CW'(1);
      h0 <= tick ? s2 : h0;
      h1 <= tick ? h0 : h1;
      stable <= stable ^ upd;
      sw_changed <= |upd;
      hex_value <= gpio_we ? gpio_wdata : hex_value;
    end
  end
  assign gpio_rdata = 32'(stable);
  for (genvar i = 0; i < 8; i++) begin : g_dig
    logic [6:0] seg;
    logic blank;
`ifdef GPIO_HEX_BLANK_LZ_EN
    localparam logic [6:0] RST_SEG = i == 0 ? 7'b1000000 : 7'b1111111;
    assign blank = i != 0 && hex_value[31:4*i] == '0;
`else
    localparam logic [6:0] RST_SEG = 7'b1000000;
    assign blank = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
      if (rst) seg <= RST_SEG;
      else seg <= blank ? 7'b1111111 : font(hex_value[4*i +: 4]);
    end
  end
  assign HEX0 = g_dig[0].seg;
  assign HEX1 = g_dig[1].seg;
  assign HEX2 = g_dig[2].seg;
  assign HEX3 = g_dig[3].seg;
  assign HEX4 = g_dig[4].seg;
  assign HEX5 = g_dig[5].seg;
  assign HEX6 = g_dig[6].seg;
  assign HEX7 = g_dig[7].seg;
endmodule

// File: tb/tb_gpio_io.sv
// tb_gpio_io: randomized bench for gpio_io against a sample-index reference model.
module tb_gpio_io;
  localparam int D = 4, N = 18;
  logic clk = 0, rst = 1, gpio_we = 0;
  logic [31:0] gpio_wdata = 0;
  logic [N-1:0] SW = '0;
  logic [31:0] gpio_rdata, hex_value;
  logic sw_changed;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  gpio_io #(.NUM_SW(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .gpio_we(gpio_we), .gpio_wdata(gpio_wdata), .SW(SW),
    .gpio_rdata(gpio_rdata), .sw_changed(sw_changed), .hex_value(hex_value),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, pulses = 0;
  logic [6:0] fnt [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`ifdef GPIO_HEX_BLANK_LZ_EN
  localparam logic [6:0] TOP0 = 7'b1111111;
`else
  localparam logic [6:0] TOP0 = 7'b1000000;
`endif
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [55:0] segs_of(input logic [31:0] v);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) begin
      r[7*i +: 7] = fnt[v[4*i +: 4]];
`ifdef GPIO_HEX_BLANK_LZ_EN
      if (i > 0 && (v >> (4*i)) == 0) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction
  // pins[k] is SW as seen at edge k after reset; tick edges are multiples of D
  int e;
  logic [N-1:0] pins [0:8191];
  logic [N-1:0] st_m, a, b, c, u;
  logic chg_m;
  logic [31:0] hv_m, hd_m;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e = 0; st_m = '0; chg_m = 0; hv_m = 0; hd_m = 0;
    end else begin
      if (e < 8191) e++;
      pins[e] = SW;
      chg_m = 0;
      hd_m = hv_m;
      if (gpio_we) hv_m = gpio_wdata;
      if (e % D == 0) begin
        a = pins[e-2];
        b = (e - 2 - D >= 1) ? pins[e-2-D] : '0;
        c = (e - 2 - 2*D >= 1) ? pins[e-2-2*D] : '0;
        u = ~(a ^ b) & ~(a ^ c) & (a ^ st_m);
        st_m = st_m ^ u;
        chg_m = |u;
      end
    end
  end
  always @(negedge clk) begin
    chk("hex_value", hex_value, hv_m);
    chk("gpio_rdata", gpio_rdata, 32'(st_m));
    chk("sw_changed", sw_changed, chg_m);
    chk("hex_segs", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, segs_of(hd_m));
    if (sw_changed) pulses++;
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    SW = 18'h3FFFF;
    step(3);
    chk("rst_hex0", HEX0, 7'b1000000);
    chk("rst_hex7", HEX7, TOP0);
    chk("rst_rdata", gpio_rdata, 0);
    chk("rst_chg", sw_changed, 0);
    rst = 0;
    for (int i = 1; i <= 2*D+1; i++) begin
      step(1);
      chk("early_rdata", gpio_rdata, 0);
    end
    step(10);
    chk("sw_all", gpio_rdata, 32'h3FFFF);
    gpio_we = 1; gpio_wdata = 32'h0123ABCD;
    step(1);
    gpio_we = 0;
    chk("wr_hexval", hex_value, 32'h0123ABCD);
    step(1);
    chk("wr_hex0", HEX0, 7'b0100001);
    chk("wr_hex1", HEX1, 7'b1000110);
    chk("wr_hex2", HEX2, 7'b0000011);
    chk("wr_hex3", HEX3, 7'b0001000);
    chk("wr_hex4", HEX4, 7'b0110000);
    chk("wr_hex5", HEX5, 7'b0100100);
    chk("wr_hex6", HEX6, 7'b1111001);
    chk("wr_hex7", HEX7, TOP0);
    for (int i = 0; i < 100; i++) begin
      gpio_wdata = $urandom;
      step(1);
    end
    chk("hold_hexval", hex_value, 32'h0123ABCD);
    chk("hold_hex0", HEX0, 7'b0100001);
    rst = 1; gpio_we = 1; gpio_wdata = 32'hFFFFFFFF;
    #1;
    chk("rstwe_hexval", hex_value, 0);
    step(1);
    chk("rstwe_hex0", HEX0, 7'b1000000);
    chk("rstwe_rdata", gpio_rdata, 0);
    gpio_we = 0; SW = '0;
    rst = 0;
    step(10);
    pulses = 0;
    SW = 18'h00005;
    step(15);
    chk("db_set", gpio_rdata, 32'h5);
    chk("db_set_pulses", pulses, 1);
    SW = '0;
    step(15);
    chk("db_clr", gpio_rdata, 0);
    chk("db_clr_pulses", pulses, 2);
    pulses = 0;
    SW = 18'h00001;
    step(3);
    SW = '0;
    step(20);
    chk("glitch_rdata", gpio_rdata, 0);
    chk("glitch_pulses", pulses, 0);
    gpio_we = 1; gpio_wdata = 32'h55;
    step(1);
    gpio_we = 0;
    SW = 18'h20000;
    step(8);
    rst = 1;
    #1;
    chk("mid_rdata", gpio_rdata, 0);
    chk("mid_hexval", hex_value, 0);
    step(1);
    rst = 0;
    for (int i = 1; i <= 2*D+1; i++) begin
      step(1);
      chk("remeasure_rdata", gpio_rdata, 0);
    end
    step(6);
    chk("remeasure_set", gpio_rdata, 32'h20000);
    for (int i = 0; i < 300; i++) begin
      int hold;
      SW = N'($urandom);
      hold = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 20));
      for (int j = 0; j < hold; j++) begin
        gpio_we = ($urandom % 8) == 0;
        gpio_wdata = $urandom;
        step(1);
      end
    end
    gpio_we = 0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpio_io.md
Name: gpio_io

Overview:
- CPU-facing GPIO peripheral for the 3-stage RISC-V core; it is the far end of the CSR GPIO interface driven by the control unit.
- CSR 0xf02 writes (gpio_we from writeback) latch a 32-bit value and drive eight active-low seven-segment displays.
- CSR 0xf00 reads return synchronized, debounced board switches.
- Sits at top level between the core's GPIO port and the board pins.

Parameters:
- NUM_SW, 18, number of switch inputs; legal range 1..32.
- DEBOUNCE_CYCLES, 500000, clk cycles between switch samples (10 ms at 50 MHz); minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- gpio_we  in  1  CSR 0xf02 write strobe from writeback stage.
- gpio_wdata  in  32  CSR write data (rs1 value).
- SW  in  NUM_SW  raw asynchronous switch pins.
- gpio_rdata  out  32  debounced switches, zero-extended; feeds CSR 0xf00 read mux.
- sw_changed  out  1  one-cycle pulse when any debounced bit changes.
- hex_value  out  32  currently latched display value.
- HEX0..HEX7  out  7 each  segments {g,f,e,d,c,b,a}, active-low; HEX0 = nibble [3:0], HEX7 = nibble [31:28].

Behaviour:
- Reset (async, dominates all inputs):
  - hex_value = 0; HEX0..HEX7 = 7'b1000000 ('0'); gpio_rdata = 0; sw_changed = 0.
  - Sync flops, sample history and tick counter are cleared.
- Display write path:
  - gpio_we high at edge N: hex_value <= gpio_wdata at edge N.
  - HEX outputs are registered decodes of hex_value and update at edge N+1.
  - gpio_we low: hex_value holds regardless of gpio_wdata.
  - Back-to-back writes: the last write wins; each write is visible in order with the same latency.
- Hex font (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Switch path:
  - Each SW bit passes through a 2-flop synchronizer.
  - Tick counter counts 0..DEBOUNCE_CYCLES-1 and wraps; the tick asserts for the cycle in which the count equals DEBOUNCE_CYCLES-1. First tick after reset is at edge DEBOUNCE_CYCLES.
  - On each tick, synchronized SW is shifted into a 3-deep sample history (per bit).
  - A stable bit updates on the tick edge where its newest three samples are equal and differ from the current stable value.
  - gpio_rdata = {(32-NUM_SW) zeros, stable}.
  - sw_changed is registered: high for exactly one cycle after any stable bit changes.
  - Latency: a clean level change appears between 2*DEBOUNCE_CYCLES+2 and 3*DEBOUNCE_CYCLES+3 cycles after the pin change.
  - Any pulse that fails to appear in three consecutive samples is rejected.
- No handshake on reads: gpio_rdata is always valid, combinationally readable, and changes only on tick edges.
- Reset asserted mid-debounce or mid-write: everything returns to reset values immediately. The counter restarts from 0 on deassertion.

Optional Feature:
- Macro GPIO_HEX_BLANK_LZ_EN.
  - Defined: digit k (k = 7..1) outputs 7'b1111111 when nibble k and all higher nibbles are zero. HEX0 is always shown. Blanking is evaluated in the same registered stage, so latency is unchanged. Reset state is HEX7..HEX1 blank and HEX0 = '0'.
  - Undefined: all eight digits always display their nibble.

Test Plan:
- Reset with SW=18'h3FFFF -> HEX0..7 = 1000000, gpio_rdata = 0, sw_changed = 0. Release reset -> gpio_rdata still 0 until at least edge 2*DEBOUNCE_CYCLES+2.
- gpio_we=1 for one cycle with wdata=32'h0123ABCD -> hex_value = 0x0123ABCD after 1 edge; after 2 edges HEX0=0100001, HEX1=1000110, HEX2=0000011, HEX3=0001000, HEX4=0110000, HEX5=0100100, HEX6=1111001, HEX7=1000000 (1111111 with GPIO_HEX_BLANK_LZ_EN).
- gpio_we=0, wdata toggling random values for 100 cycles -> hex_value and HEX unchanged. Simultaneous rst and gpio_we -> reset values.
- DEBOUNCE_CYCLES=4: SW=18'h00005 held from cycle 10 -> gpio_rdata = 32'h5 within 15 cycles, exactly one sw_changed pulse. SW back to 0 -> returns to 0 with one more pulse.
- DEBOUNCE_CYCLES=4: SW[0] high for 3 cycles then low -> gpio_rdata stays 0, no sw_changed.
- Assert rst for 1 cycle mid-debounce after SW=18'h20000 -> gpio_rdata = 0 immediately, hex_value = 0. Full debounce latency is re-measured from reset release.
